memory_responder: RTL and testbench

- Memory-side responder for the core's combined instruction/data memory port. It is the target end of the core's memory-access interface.
- Accepts one read or write request at a time over a valid/ready request channel, inserts a programmable number of wait states, then returns read data or a write acknowledgement over a valid/ready response channel.
- Replaces the zero-latency memory model so that the multi-cycle core controller is exercised against realistic, stallable memory timing.

---
 rtl/memory_responder.sv | 110 +++++++++++
 tb/tb_memory_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Memory-side responder: accepts one request at a time, inserts WAIT_CYCLES wait states,
// and returns read data or a write acknowledgement over a valid/ready response channel.
module memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_arstn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_address,
  input  logic [31:0] i_req_writeData,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_readData,
  output logic        o_rsp_error
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_write;
  logic            r_err;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_rsp_err;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_req_err;
  logic [AW-1:0]   w_req_idx;
  logic            w_accept;
  logic            w_commit;
  logic            w_cmd_write;
  logic            w_cmd_err;
  logic [AW-1:0]   w_cmd_idx;
  logic [31:0]     w_cmd_wdata;

  // Any set bit above the word index means the address is past the last word (no wrap).
  assign w_req_err = (i_req_address[1:0] != 2'b00) || (i_req_address[31:AW+2] != '0);
  assign w_req_idx = i_req_address[AW+1:2];

  assign w_accept = (r_state == IDLE) && i_req_valid;
  assign w_commit = (WAIT_CYCLES == 0) ? w_accept : ((r_state == WAIT) && (r_cnt == 4'd0));

  // With zero wait states the commit edge is the acceptance edge, so use the live request.
  assign w_cmd_write = (r_state == IDLE) ? i_req_write     : r_write;
  assign w_cmd_err   = (r_state == IDLE) ? w_req_err       : r_err;
  assign w_cmd_idx   = (r_state == IDLE) ? w_req_idx       : r_idx;
  assign w_cmd_wdata = (r_state == IDLE) ? i_req_writeData : r_wdata;

  assign o_req_ready    = (r_state == IDLE);
  assign o_rsp_valid    = (r_state == RESP);
  assign o_rsp_readData = r_rdata;
  assign o_rsp_error    = r_rsp_err;

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_commit) begin
        r_rdata   <= (!w_cmd_write && !w_cmd_err) ? r_mem[w_cmd_idx] : '0;
        r_rsp_err <= w_cmd_err;
      end
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_write <= i_req_write;
            r_err   <= w_req_err;
            r_idx   <= w_req_idx;
            r_wdata <= i_req_writeData;
            if (WAIT_CYCLES == 0) begin
              r_state <= RESP;
            end else begin
              r_cnt   <= 4'(WAIT_CYCLES - 1);
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_state   <= IDLE;
            r_rdata   <= '0;
            r_rsp_err <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; an aborted write never reaches the commit edge.
  always_ff @(posedge i_clk) begin
    if (w_commit && w_cmd_write && !w_cmd_err) r_mem[w_cmd_idx] <= w_cmd_wdata;
  end
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one instance with two wait states, one with none.
module tb_memory_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arstn;
  logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int total = 0;
  int bad   = 0;

  memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_a (
    .i_clk(clk), .i_arstn(arstn),
    .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_write(a_req_write),
    .i_req_address(a_addr), .i_req_writeData(a_wdata),
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready),
    .o_rsp_readData(a_rdata), .o_rsp_error(a_err)
  );

  memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_b (
    .i_clk(clk), .i_arstn(arstn),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_write(b_req_write),
    .i_req_address(b_addr), .i_req_writeData(b_wdata),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready),
    .o_rsp_readData(b_rdata), .o_rsp_error(b_err)
  );

  // Called at a negedge with u_a idle. lat counts edges after the capturing edge until
  // o_rsp_valid is seen, i.e. WAIT_CYCLES for a request presented in the cycle after edge N.
  task automatic a_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       output int lat, output logic [31:0] rd, output logic er);
    a_req_valid = 1'b1; a_req_write = wr; a_addr = addr; a_wdata = data;
    @(negedge clk);
    a_req_valid = 1'b0; a_req_write = ~wr; a_addr = 32'h44; a_wdata = 32'hFFFF_FFFF;
    lat = 0;
    while (!a_rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = a_rdata; er = a_err;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    a_req_valid = 0; a_req_write = 0; a_addr = 0; a_wdata = 0; a_rsp_ready = 0;
    b_req_valid = 0; b_req_write = 0; b_addr = 0; b_wdata = 0; b_rsp_ready = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({a_rsp_valid, a_rdata, a_err} !== 34'h0) begin
      bad++; $display("FAIL reset_hold got v=%b d=%h e=%b want 0/0/0", a_rsp_valid, a_rdata, a_err);
    end
    arstn = 1'b1;
    @(negedge clk);
    total++;
    if ({a_req_ready, a_rsp_valid, a_rdata, a_err} !== {1'b1, 34'h0}) begin
      bad++; $display("FAIL reset_release got rdy=%b v=%b d=%h e=%b want 1/0/0/0",
                      a_req_ready, a_rsp_valid, a_rdata, a_err);
    end
    total++;
    if ({b_req_ready, b_rsp_valid} !== 2'b10) begin
      bad++; $display("FAIL reset_b got rdy=%b v=%b want 1/0", b_req_ready, b_rsp_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin
        bad++; $display("FAIL idle_no_rsp got a=%b b=%b want 0/0", a_rsp_valid, b_rsp_valid);
      end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er;
    a_txn(1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
    total++;
    if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
      bad++; $display("FAIL write_rsp got lat=%0d d=%h e=%b want 2/0/0", lat, rd, er);
    end
    total++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL write_done got rdy=%b v=%b want 1/0", a_req_ready, a_rsp_valid);
    end
    a_txn(1'b0, 32'h10, 32'h0, lat, rd, er);
    total++;
    if (lat !== 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      bad++; $display("FAIL read_back got lat=%0d d=%h e=%b want 2/deadbeef/0", lat, rd, er);
    end
  endtask

  task automatic test_zero_wait();
    b_req_valid = 1'b1; b_req_write = 1'b1; b_addr = 32'h10; b_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    b_req_valid = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
    total++;
    if ({b_rsp_valid, b_req_ready, b_rdata, b_err} !== {2'b10, 33'h0}) begin
      bad++; $display("FAIL zw_write got v=%b rdy=%b d=%h e=%b want 1/0/0/0",
                      b_rsp_valid, b_req_ready, b_rdata, b_err);
    end
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
    b_req_valid = 1'b1; b_req_write = 1'b0; b_addr = 32'h10;
    @(negedge clk);
    b_req_valid = 1'b0;
    total++;
    if (b_rsp_valid !== 1'b1 || b_rdata !== 32'hCAFE_F00D || b_err !== 1'b0) begin
      bad++; $display("FAIL zw_read got v=%b d=%h e=%b want 1/cafef00d/0", b_rsp_valid, b_rdata, b_err);
    end
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
    total++;
    if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL zw_idle got rdy=%b v=%b want 1/0", b_req_ready, b_rsp_valid);
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    a_txn(1'b1, 32'h0, 32'h1111_2222, lat, rd, er);
    a_txn(1'b0, 32'h13, 32'h0, lat, rd, er);
    total++;
    if (lat !== 2 || rd !== 32'h0 || er !== 1'b1) begin
      bad++; $display("FAIL err_misalign got lat=%0d d=%h e=%b want 2/0/1", lat, rd, er);
    end
    a_txn(1'b1, 32'h400, 32'h9999_9999, lat, rd, er);
    total++;
    if (lat !== 2 || rd !== 32'h0 || er !== 1'b1) begin
      bad++; $display("FAIL err_range got lat=%0d d=%h e=%b want 2/0/1", lat, rd, er);
    end
    a_txn(1'b1, 32'h3FC, 32'hA5A5_A5A5, lat, rd, er);
    total++;
    if (er !== 1'b0) begin
      bad++; $display("FAIL last_word_wr got e=%b want 0", er);
    end
    a_txn(1'b0, 32'h3FC, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'hA5A5_A5A5 || er !== 1'b0) begin
      bad++; $display("FAIL last_word_rd got d=%h e=%b want a5a5a5a5/0", rd, er);
    end
    a_txn(1'b0, 32'h0, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'h1111_2222 || er !== 1'b0) begin
      bad++; $display("FAIL no_wrap got d=%h e=%b want 11112222/0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic er;
    a_txn(1'b1, 32'h30, 32'h5555_AAAA, lat, rd, er);
    a_req_valid = 1'b1; a_req_write = 1'b0; a_addr = 32'h30;
    @(negedge clk);
    a_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    // A competing write to the same word must be ignored while the response is held.
    a_req_valid = 1'b1; a_req_write = 1'b1; a_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({a_rsp_valid, a_req_ready, a_rdata, a_err} !== {2'b10, 32'h5555_AAAA, 1'b0}) begin
        bad++; $display("FAIL bp_hold%0d got v=%b rdy=%b d=%h e=%b want 1/0/5555aaaa/0",
                        i, a_rsp_valid, a_req_ready, a_rdata, a_err);
      end
      @(negedge clk);
    end
    a_req_valid = 1'b0; a_req_write = 1'b0;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    total++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got rdy=%b v=%b want 1/0", a_req_ready, a_rsp_valid);
    end
    a_txn(1'b0, 32'h30, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'h5555_AAAA) begin
      bad++; $display("FAIL bp_no_accept got d=%h want 5555aaaa", rd);
    end
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] rd; logic er;
    a_txn(1'b1, 32'h20, 32'h0BAD_F00D, lat, rd, er);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_addr = 32'h20; a_wdata = 32'h1234_5678;
    @(negedge clk);
    a_req_valid = 1'b0;
    total++;
    if (a_req_ready !== 1'b0) begin
      bad++; $display("FAIL ar_in_wait got rdy=%b want 0", a_req_ready);
    end
    #2 arstn = 1'b0;
    #1;
    total++;
    if ({a_req_ready, a_rsp_valid, a_rdata, a_err} !== {1'b1, 34'h0}) begin
      bad++; $display("FAIL ar_wait_async got rdy=%b v=%b d=%h e=%b want 1/0/0/0",
                      a_req_ready, a_rsp_valid, a_rdata, a_err);
    end
    @(negedge clk); @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    a_txn(1'b0, 32'h20, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'h0BAD_F00D || er !== 1'b0) begin
      bad++; $display("FAIL ar_discard got d=%h e=%b want 0badf00d/0", rd, er);
    end
    // Abort during RESP: held read data must drop without a clock edge.
    a_req_valid = 1'b1; a_req_write = 1'b0; a_addr = 32'h20;
    @(negedge clk);
    a_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (a_rsp_valid !== 1'b1 || a_rdata !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL ar_pre_resp got v=%b d=%h want 1/0badf00d", a_rsp_valid, a_rdata);
    end
    #2 arstn = 1'b0;
    #1;
    total++;
    if ({a_req_ready, a_rsp_valid, a_rdata, a_err} !== {1'b1, 34'h0}) begin
      bad++; $display("FAIL ar_resp_async got rdy=%b v=%b d=%h e=%b want 1/0/0/0",
                      a_req_ready, a_rsp_valid, a_rdata, a_err);
    end
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_errors();
    test_backpressure();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
